// File: rtl/ht_stream_pkg.sv
// ---------------------------------------------------------------------------
// ht_stream_pkg
// Shared definitions for the hash_table ingress stream path.
//   DATA_WIDTH_DEF : default beat width, matches hash_table DATA_WIDTH
//   beat_t         : one stored FIFO entry {last, data} at the default width
//   ptr_w()        : FIFO pointer width for a given depth (address + wrap bit)
// ---------------------------------------------------------------------------
package ht_stream_pkg;

  localparam int DATA_WIDTH_DEF = 64;

  typedef struct packed {
    logic                      last;
    logic [DATA_WIDTH_DEF-1:0] data;
  } beat_t;

  // One extra MSB beyond the address bits distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_ingress_fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage for axis_ingress_fifo: synchronous write,
// asynchronous read, no reset on the array.
//   clk        : write clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : entry to store
//   i_rd_addr  : read address
//   o_rd_data  : entry at i_rd_addr (combinational)
// ---------------------------------------------------------------------------
module fifo_ram
  import ht_stream_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = beat_t
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  T                         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output T                         o_rd_data
);

  T r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_ingress_fifo.sv
// ---------------------------------------------------------------------------
// axis_ingress_fifo
// Burst buffer in front of hash_table. In packet mode a burst is only
// presented once its last beat is stored (or the FIFO fills, see r_cut).
// In plain mode it is a first-word-fall-through FIFO.
//   clk, reset  : single clock, synchronous active-high reset
//   data_i/valid_i/last_i/ready_o : host side beat handshake
//   data_o/valid_o/last_o/ready_i : hash_table side beat handshake
//   count_o     : beats stored
//   packets_o   : complete bursts stored (last beats held)
// ---------------------------------------------------------------------------
module axis_ingress_fifo
  import ht_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   valid_o,
  output logic                   last_o,
  input  logic                   ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] packets_o
);

  localparam int             PW      = ptr_w(DEPTH);
  localparam int             AW      = PW - 1;
  localparam bit             PKT     = (PACKET_MODE != 0);
  localparam logic [PW-1:0]  PTR_MSB = {1'b1, {AW{1'b0}}};

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } fifo_beat_t;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_packets;
  logic          r_ready;
  // Set once the FIFO has filled with no complete burst behind the head:
  // the head burst then streams out (cut-through) until its last beat pops,
  // so a burst longer than DEPTH cannot deadlock.
  logic          r_cut;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_full_nxt;
  logic          w_valid;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  fifo_beat_t    w_wr_beat;
  fifo_beat_t    w_rd_beat;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == PTR_MSB);
  assign w_valid = !w_empty && (!PKT || (r_packets != '0) || w_full || r_cut);

  assign w_push  = valid_i && r_ready;
  assign w_pop   = w_valid && ready_i;

  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  // ready_o is registered from the post-edge occupancy, so it never has a
  // combinational path from valid_i or ready_i.
  assign w_full_nxt   = ((w_wr_ptr_nxt ^ w_rd_ptr_nxt) == PTR_MSB);

  assign w_wr_beat.last = last_i;
  assign w_wr_beat.data = data_i;

  fifo_ram #(
    .DEPTH (DEPTH),
    .T     (fifo_beat_t)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_wr_beat),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_beat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_packets <= '0;
      r_ready   <= 1'b0;
      r_cut     <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_ready  <= !w_full_nxt;

      unique case ({w_push && last_i, w_pop && w_rd_beat.last})
        2'b10:   r_packets <= r_packets + PW'(1);
        2'b01:   r_packets <= r_packets - PW'(1);
        default: r_packets <= r_packets;
      endcase

      if (w_pop && w_rd_beat.last) begin
        r_cut <= 1'b0;
      end else if (w_full) begin
        r_cut <= 1'b1;
      end
    end
  end

  assign ready_o   = r_ready;
  assign valid_o   = w_valid;
  assign data_o    = w_rd_beat.data;
  assign last_o    = w_rd_beat.last;
  assign count_o   = r_wr_ptr - r_rd_ptr;
  assign packets_o = r_packets;

endmodule
